// File: rtl/rx_fifo_pkg.sv
// Shared UART constants: byte width and default receive FIFO depth.
package rx_fifo_pkg;

  localparam int unsigned UartDataW   = 8;
  localparam int unsigned RxFifoDepth = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x byte register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module uart_fifo_mem
  import rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = RxFifoDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [UartDataW-1:0] wdata_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [UartDataW-1:0] rdata_o
);

  logic [UartDataW-1:0] mem_q [DEPTH];

  // Store the incoming byte at the write address when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO between the UART receive state machine and the bus side. First-word-fall-
// through read, occupancy count, level interrupt, synchronous flush and sticky underflow.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = RxFifoDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                 glb_clk,
  input  logic                 glb_rstn,
  input  logic                 STM_ctrl_FIFO_w_en,
  input  logic [UartDataW-1:0] STM_data_payload,
  output logic                 FIFO_ctrl_full,
  input  logic                 Bus_ctrl_rd_en,
  output logic [UartDataW-1:0] FIFO_data_rdata,
  output logic                 FIFO_ctrl_empty,
  output logic [ADDR_W:0]      FIFO_ctrl_count,
  input  logic [ADDR_W:0]      Cfg_ctrl_rx_thresh,
  output logic                 FIFO_ctrl_thresh_irq,
  input  logic                 Cfg_ctrl_fifo_clr,
  output logic                 FIFO_ctrl_underflow
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [ADDR_W-1:0]    wptr_q, wptr_d;
  logic [ADDR_W-1:0]    rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 uflow_q, uflow_d;
  logic                 wr_accept, rd_accept;
  logic [UartDataW-1:0] head_data;

  // Full/empty come only from the registered count, never from pointer comparison.
  assign FIFO_ctrl_full  = (count_q == FullCount);
  assign FIFO_ctrl_empty = (count_q == '0);
  assign wr_accept       = STM_ctrl_FIFO_w_en & ~FIFO_ctrl_full;
  assign rd_accept       = Bus_ctrl_rd_en & ~FIFO_ctrl_empty;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (glb_clk),
    .we_i    (wr_accept & ~Cfg_ctrl_fifo_clr),
    .waddr_i (wptr_q),
    .wdata_i (STM_data_payload),
    .raddr_i (rptr_q),
    .rdata_o (head_data)
  );

  // Next-state for pointers, occupancy and the sticky underflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    uflow_d = uflow_q;
    if (Cfg_ctrl_fifo_clr) begin
      // Flush wins over any concurrent write or pop.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      uflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + ADDR_W'(1);
      end
      if (rd_accept) begin
        rptr_d = rptr_q + ADDR_W'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      // A pop on empty only counts as underflow when no write fills the FIFO that cycle.
      if (Bus_ctrl_rd_en && FIFO_ctrl_empty && !wr_accept) begin
        uflow_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge glb_clk) begin
    if (!glb_rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      uflow_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      uflow_q <= uflow_d;
    end
  end

  // Storage is unreset, so mask the head byte while empty.
  assign FIFO_data_rdata      = FIFO_ctrl_empty ? '0 : head_data;
  assign FIFO_ctrl_count      = count_q;
  assign FIFO_ctrl_thresh_irq = (Cfg_ctrl_rx_thresh != '0) && (count_q >= Cfg_ctrl_rx_thresh);
  assign FIFO_ctrl_underflow  = uflow_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo with a byte scoreboard and an occupancy/flag model.
module tb_rx_fifo;

  localparam int Depth = 16;

  logic       glb_clk = 1'b0;
  logic       glb_rstn;
  logic       w_en;
  logic [7:0] wdata;
  logic       full;
  logic       rd_en;
  logic [7:0] rdata;
  logic       empty;
  logic [4:0] count;
  logic [4:0] thresh;
  logic       irq;
  logic       clr;
  logic       uflow;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb [$];
  logic       uflow_m = 1'b0;

  always #5 glb_clk = ~glb_clk;

  rx_fifo #(
    .DEPTH  (Depth),
    .ADDR_W (4)
  ) dut (
    .glb_clk              (glb_clk),
    .glb_rstn             (glb_rstn),
    .STM_ctrl_FIFO_w_en   (w_en),
    .STM_data_payload     (wdata),
    .FIFO_ctrl_full       (full),
    .Bus_ctrl_rd_en       (rd_en),
    .FIFO_data_rdata      (rdata),
    .FIFO_ctrl_empty      (empty),
    .FIFO_ctrl_count      (count),
    .Cfg_ctrl_rx_thresh   (thresh),
    .FIFO_ctrl_thresh_irq (irq),
    .Cfg_ctrl_fifo_clr    (clr),
    .FIFO_ctrl_underflow  (uflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model after an edge.
  task automatic check_state(input string tag);
    logic [7:0] exp_head;
    exp_head = (sb.size() != 0) ? sb[0] : 8'h00;
    check({tag, ".count"}, 32'(count), 32'(sb.size()));
    check({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    check({tag, ".full"},  32'(full),  32'(sb.size() == Depth));
    check({tag, ".rdata"}, 32'(rdata), 32'(exp_head));
    check({tag, ".uflow"}, 32'(uflow), 32'(uflow_m));
    check({tag, ".irq"},   32'(irq),   32'((thresh != 0) && (sb.size() >= int'(thresh))));
  endtask

  // One clock: drive inputs, check popped byte, update model, check outputs after the edge.
  task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r,
                      input logic c);
    bit full_m, empty_m, wacc, racc;
    w_en  = w;
    wdata = d;
    rd_en = r;
    clr   = c;
    #1;
    full_m  = (sb.size() == Depth);
    empty_m = (sb.size() == 0);
    wacc    = w && !full_m;
    racc    = r && !empty_m;
    if (!glb_rstn || c) begin
      sb.delete();
      uflow_m = 1'b0;
    end else begin
      if (racc) begin
        check({tag, ".pop"}, 32'(rdata), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (wacc) sb.push_back(d);
      if (r && empty_m && !wacc) uflow_m = 1'b1;
    end
    @(posedge glb_clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    glb_rstn = 1'b0;
    w_en     = 1'b0;
    wdata    = 8'h00;
    rd_en    = 1'b0;
    clr      = 1'b0;
    thresh   = 5'd0;
    @(posedge glb_clk);
    #1;
    step("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    glb_rstn = 1'b1;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Three writes then three pops.
    step("w55", 1'b1, 8'h55, 1'b0, 1'b0);
    step("wAA", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("w0F", 1'b1, 8'h0F, 1'b0, 1'b0);
    check("three.count", 32'(count), 32'd3);
    check("three.head", 32'(rdata), 32'h55);
    for (int i = 0; i < 3; i++) step("pop3", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drained.rdata", 32'(rdata), 32'h00);

    // Fill to full, hold a 17th write, free one slot and let it land.
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'd1);
    step("blocked", 1'b1, 8'hF0, 1'b0, 1'b0);
    check("blocked.count", 32'(count), 32'd16);
    step("pop_full", 1'b1, 8'hF0, 1'b1, 1'b0);
    check("pop_full.count", 32'(count), 32'd15);
    step("landed", 1'b1, 8'hF0, 1'b0, 1'b0);
    check("landed.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous write and pop on empty, then a real underflow.
    step("wr_rd_empty", 1'b1, 8'h3C, 1'b1, 1'b0);
    check("wr_rd_empty.uflow", 32'(uflow), 32'd0);
    check("wr_rd_empty.rdata", 32'(rdata), 32'h3C);
    step("pop3C", 1'b0, 8'h00, 1'b1, 1'b0);
    step("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
    check("underflow.flag", 32'(uflow), 32'd1);
    step("sticky", 1'b0, 8'h00, 1'b0, 1'b0);
    step("clr_uflow", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_uflow.flag", 32'(uflow), 32'd0);

    // Threshold interrupt.
    thresh = 5'd4;
    for (int i = 1; i <= 4; i++) step("thr_w", 1'b1, 8'(i), 1'b0, 1'b0);
    check("thr.irq_on", 32'(irq), 32'd1);
    step("thr_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("thr.irq_off", 32'(irq), 32'd0);
    for (int i = 0; i < 13; i++) step("thr_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    thresh = 5'd0;
    step("thr_zero", 1'b0, 8'h00, 1'b0, 1'b0);
    check("thr_zero.irq", 32'(irq), 32'd0);
    thresh = 5'd20;
    step("thr_high", 1'b0, 8'h00, 1'b0, 1'b0);
    check("thr_high.irq", 32'(irq), 32'd0);
    thresh = 5'd0;
    step("thr_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Steady streaming at count 8 across several pointer wraps.
    for (int i = 0; i < 8; i++) step("pre8", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    check("stream.count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step("stream_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with concurrent write and pop, then reset mid-stream with w_en held.
    for (int i = 0; i < 10; i++) step("pre10", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step("clr_busy", 1'b1, 8'hEE, 1'b1, 1'b1);
    check("clr_busy.count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    glb_rstn = 1'b0;
    step("mid_rst", 1'b1, 8'h77, 1'b0, 1'b0);
    check("mid_rst.empty", 32'(empty), 32'd1);
    glb_rstn = 1'b1;
    step("post_rst", 1'b1, 8'h77, 1'b0, 1'b0);
    check("post_rst.count", 32'(count), 32'd1);
    check("post_rst.rdata", 32'(rdata), 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
